// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - valid/ready bus between fetch side, immediate decoder and execute side
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_imm_sel;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_imm_sel, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_imm_sel, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder behind a two-entry valid/ready skid stage
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  imm_gen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("imm_gen_pipe: TAG_W must be at least 1");
  end

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_SB    = 3'd2;
  localparam logic [2:0] SEL_UJ    = 3'd3;
  localparam logic [2:0] SEL_U     = 3'd4;
  localparam logic [2:0] SEL_Z     = 3'd5;
  localparam logic [2:0] SEL_SHAMT = 3'd6;

  logic [31:0]      instr;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             unused_opcode;

  assign instr         = bus.in_instr;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32   = '0;
    dec_err = 1'b0;
    case (bus.in_imm_sel)
      SEL_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      SEL_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_SB: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_UJ: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_U:  imm32 = {instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    dec_imm = XLEN'($signed(imm32));
    case (bus.in_imm_sel)
      SEL_Z: begin
        if (ZIMM_EN) dec_imm = XLEN'(instr[19:15]);
        else         dec_err = 1'b1;
      end
      SEL_SHAMT: begin
        if (!ZIMM_EN)        dec_err = 1'b1;
        else if (XLEN == 64) dec_imm = XLEN'(instr[25:20]);
        else                 dec_imm = XLEN'(instr[24:20]);
      end
      3'd7:    dec_err = 1'b1;
      default: dec_err = 1'b0;
    endcase
    if (dec_err) dec_imm = '0;
  end

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_err_q, main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             skid_err_q;
  logic             in_ready_q;
  logic             in_acc;
  logic             main_free;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;

  assign in_acc    = bus.in_valid & in_ready_q;
  assign main_free = !main_valid_q | bus.out_ready;

  // Skid only fills when main is stalled, so main never loads from input while skid holds data.
  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        main_valid_d   = 1'b1;
        skid_valid_d   = 1'b0;
      end else if (in_acc) begin
        main_load    = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_acc) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
    main_imm_d = main_from_skid ? skid_imm_q : dec_imm;
    main_tag_d = main_from_skid ? skid_tag_q : bus.in_tag;
    main_err_d = main_from_skid ? skid_err_q : dec_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      if (main_load) begin
        main_imm_q <= main_imm_d;
        main_tag_q <= main_tag_d;
        main_err_q <= main_err_d;
      end
      if (skid_load) begin
        skid_imm_q <= dec_imm;
        skid_tag_q <= bus.in_tag;
        skid_err_q <= dec_err;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_err   = main_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed checks of imm_gen_pipe against a queue model
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic iv;
  logic [2:0] sel;
  logic [31:0] ins;
  logic [31:0] tg;
  logic ordy;
  int tests_run = 0;
  int tests_failed = 0;
  bit acc, drn;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if_a ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if_b ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if_c ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZIMM_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .flush(flush), .bus(if_a));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ZIMM_EN(1'b1)) dut_b (.clk(clk), .rst(rst), .flush(flush), .bus(if_b));
  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZIMM_EN(1'b0)) dut_c (.clk(clk), .rst(rst), .flush(flush), .bus(if_c));

  assign if_a.in_valid = iv;  assign if_b.in_valid = iv;  assign if_c.in_valid = iv;
  assign if_a.in_imm_sel = sel; assign if_b.in_imm_sel = sel; assign if_c.in_imm_sel = sel;
  assign if_a.in_instr = ins; assign if_b.in_instr = ins; assign if_c.in_instr = ins;
  assign if_a.in_tag = tg;    assign if_b.in_tag = tg;    assign if_c.in_tag = tg;
  assign if_a.out_ready = ordy; assign if_b.out_ready = ordy; assign if_c.out_ready = ordy;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] ins;
    logic [31:0] tag;
  } beat_t;
  beat_t q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_imm(input int xlen, input bit zen, input logic [2:0] s_sel,
                                          input logic [31:0] s_ins, output logic err);
    logic signed [63:0] s, t;
    logic [63:0] v;
    s = $signed(s_ins);
    v = '0;
    err = 1'b0;
    case (s_sel)
      3'd0: begin t = s >>> 20; v = t; end
      3'd1: begin t = s >>> 25; v = (t << 5) | 64'(s_ins[11:7]); end
      3'd2: begin
        t = s >>> 31;
        v = (t << 12) | (64'(s_ins[7]) << 11) | (64'(s_ins[30:25]) << 5) | (64'(s_ins[11:8]) << 1);
      end
      3'd3: begin
        t = s >>> 31;
        v = (t << 20) | (64'(s_ins[19:12]) << 12) | (64'(s_ins[20]) << 11) | (64'(s_ins[30:21]) << 1);
      end
      3'd4: begin t = s >>> 12; v = t << 12; end
      3'd5: if (zen) v = 64'(s_ins[19:15]); else err = 1'b1;
      3'd6: if (zen) v = (xlen == 64) ? 64'(s_ins[25:20]) : 64'(s_ins[24:20]); else err = 1'b1;
      default: err = 1'b1;
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic check_all();
    logic [63:0] e;
    logic er;
    check("a_out_valid", if_a.out_valid, q.size() > 0);
    check("b_out_valid", if_b.out_valid, q.size() > 0);
    check("c_out_valid", if_c.out_valid, q.size() > 0);
    check("a_in_ready", if_a.in_ready, q.size() < 2);
    check("b_in_ready", if_b.in_ready, q.size() < 2);
    check("c_in_ready", if_c.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      e = ref_imm(32, 1'b1, q[0].sel, q[0].ins, er);
      check("a_imm", if_a.out_imm, e); check("a_err", if_a.out_err, er); check("a_tag", if_a.out_tag, q[0].tag);
      e = ref_imm(64, 1'b1, q[0].sel, q[0].ins, er);
      check("b_imm", if_b.out_imm, e); check("b_err", if_b.out_err, er); check("b_tag", if_b.out_tag, q[0].tag);
      e = ref_imm(32, 1'b0, q[0].sel, q[0].ins, er);
      check("c_imm", if_c.out_imm, e); check("c_err", if_c.out_err, er); check("c_tag", if_c.out_tag, q[0].tag);
    end
  endtask

  // Called just after a falling edge with this cycle's inputs already applied.
  task automatic cycle();
    beat_t b;
    check_all();
    acc = iv && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    b.sel = sel; b.ins = ins; b.tag = tg;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic kat(input logic [2:0] k_sel, input logic [31:0] k_ins, input logic [63:0] e32,
                     input logic [63:0] e64, input logic e_err, input logic c_err);
    ordy = 1'b1; iv = 1'b1; sel = k_sel; ins = k_ins; tg = tg + 1;
    cycle();
    iv = 1'b0;
    check("kat_valid", if_a.out_valid, 1'b1);
    check("kat_a_imm", if_a.out_imm, e32);
    check("kat_b_imm", if_b.out_imm, e64);
    check("kat_a_err", if_a.out_err, e_err);
    check("kat_c_err", if_c.out_err, c_err);
    check("kat_c_imm", if_c.out_imm, c_err ? 64'd0 : e32);
    cycle();
  endtask

  int obs_tag[4];
  int obs_k[4];
  int n;
  int next_tag;

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; sel = '0; ins = '0; tg = '0;
    #1;
    check("rst_out_valid", if_a.out_valid, 1'b0);
    check("rst_in_ready", if_a.in_ready, 1'b1);
    check("rst_out_imm", if_b.out_imm, 64'd0);
    check("rst_out_tag", if_a.out_tag, 64'd0);
    check("rst_out_err", if_a.out_err, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    kat(3'd0, 32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    kat(3'd1, 32'hFE112E23, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    kat(3'd3, 32'hFF9FF06F, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    kat(3'd2, 32'hFE000EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    kat(3'd4, 32'h12345037, 64'h1234_5000, 64'h0000_0000_1234_5000, 1'b0, 1'b0);
    kat(3'd4, 32'h80000037, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    kat(3'd6, 32'h03F0D093, 64'h1F, 64'h3F, 1'b0, 1'b1);
    kat(3'd5, 32'h3400F073, 64'h1, 64'h1, 1'b0, 1'b1);
    kat(3'd7, 32'hFFFFFFFF, 64'h0, 64'h0, 1'b1, 1'b1);

    // Backpressure: two beats fill main and skid, then release and watch order
    ordy = 1'b0; iv = 1'b1; sel = 3'd0; ins = $urandom; tg = 1;
    cycle();
    ins = $urandom; tg = 2;
    cycle();
    check("bp_in_ready", if_a.in_ready, 1'b0);
    ins = $urandom; tg = 3;
    cycle();
    cycle();
    check("bp_hold_tag", if_a.out_tag, 64'd1);
    ordy = 1'b1; n = 0; next_tag = 3;
    for (int k = 0; k < 20 && n < 4; k++) begin
      if (if_a.out_valid) begin
        obs_tag[n] = int'(if_a.out_tag);
        obs_k[n] = k;
        n++;
      end
      cycle();
      if (acc && iv) begin
        next_tag++;
        if (next_tag > 4) iv = 1'b0;
        else begin tg = next_tag; ins = $urandom; end
      end
    end
    iv = 1'b0;
    check("bp_count", n, 4);
    for (int i = 0; i < n; i++) begin
      check("bp_order", obs_tag[i], i + 1);
      check("bp_no_gap", obs_k[i], i);
    end

    // Flush with main and skid full, then with only main full and in_ready high
    for (int pass = 0; pass < 2; pass++) begin
      ordy = 1'b0; iv = 1'b1; tg = 5; ins = $urandom;
      cycle();
      if (pass == 0) begin tg = 6; ins = $urandom; cycle(); end
      flush = 1'b1; tg = 9; ins = $urandom;
      cycle();
      flush = 1'b0; iv = 1'b0; ordy = 1'b1;
      check("fl_out_valid", if_a.out_valid, 1'b0);
      check("fl_in_ready", if_a.in_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
        check("fl_no_tag9", if_a.out_valid, 1'b0);
        cycle();
      end
    end

    // Asynchronous reset between edges with beats buffered
    ordy = 1'b0; iv = 1'b1; sel = 3'd0; ins = 32'hFFF00093; tg = 7;
    cycle();
    tg = 8;
    cycle();
    tg = 10;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", if_a.out_valid, 1'b0);
    check("arst_out_imm", if_b.out_imm, 64'd0);
    check("arst_out_tag", if_a.out_tag, 64'd0);
    check("arst_out_err", if_a.out_err, 1'b0);
    check("arst_in_ready", if_a.in_ready, 1'b1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; iv = 1'b0;
    check("arst_in_ignored", if_a.out_valid, 1'b0);
    cycle();

    for (int k = 0; k < 1500; k++) begin
      iv = ($urandom % 10) < 7;
      sel = 3'($urandom % 8);
      ins = $urandom;
      tg = $urandom;
      ordy = ($urandom % 10) < 6;
      flush = ($urandom % 50) == 0;
      cycle();
    end
    flush = 1'b0; iv = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
